// File: rtl/serial_eq_checker.sv
// rtl/serial_eq_checker.sv - serial LSB-first word comparator, one bit pair per accepted beat.
// Optional mismatch_cnt output is enabled by defining SERIAL_EQ_MISMATCH_COUNT_EN.
module serial_eq_checker #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic       x,
  input  logic       y,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       equal,
  output logic [5:0] first_diff
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
  ,
  output logic [5:0] mismatch_cnt
`endif
);

  localparam logic [5:0] W6   = 6'(WIDTH);
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [5:0] cnt;
  logic       match;
  logic       found;
  logic [5:0] fd;
  logic       pair_miss;
  logic [5:0] fd_next;

  assign pair_miss = x ^ y;
  // First mismatch index including the pair being accepted this cycle.
  assign fd_next   = found ? fd : (pair_miss ? cnt : W6);

`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
  logic [5:0] mm;
  logic [5:0] mm_next;
  assign mm_next = (pair_miss && (mm != W6)) ? mm + 6'd1 : mm;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      match      <= 1'b1;
      found      <= 1'b0;
      fd         <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      equal      <= 1'b0;
      first_diff <= '0;
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
      mm           <= '0;
      mismatch_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            match      <= 1'b1;
            found      <= 1'b0;
            fd         <= '0;
            equal      <= 1'b0;
            first_diff <= '0;
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
            mm           <= '0;
            mismatch_cnt <= '0;
`endif
          end
        end
        RUN: begin
          if (in_valid) begin
            match <= match & ~pair_miss;
            if (pair_miss && !found) begin
              found <= 1'b1;
              fd    <= cnt;
            end
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
            mm <= mm_next;
`endif
            if (cnt == LAST) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              done       <= 1'b1;
              equal      <= match & ~pair_miss;
              first_diff <= fd_next;
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
              mismatch_cnt <= mm_next;
`endif
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq_checker.sv
// tb/tb_serial_eq_checker.sv - scoreboard bench for serial_eq_checker with a word-level reference model.
module tb_serial_eq_checker;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, x, y;
  logic       in_ready, busy, done, equal;
  logic [5:0] first_diff;
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
  logic [5:0] mismatch_cnt;
`endif

  serial_eq_checker #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .x(x), .y(y),
    .in_ready(in_ready), .busy(busy), .done(done), .equal(equal), .first_diff(first_diff)
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
    , .mismatch_cnt(mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       eq;
    logic [5:0] fd;
    logic [5:0] mm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  int   words = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: result follows directly from the XOR of the two words.
  function automatic exp_t model(input logic [W-1:0] xw, input logic [W-1:0] yw);
    exp_t e;
    logic [W-1:0] d;
    d    = xw ^ yw;
    e.eq = (d == '0);
    e.fd = 6'(W);
    for (int i = W - 1; i >= 0; i--) if (d[i]) e.fd = 6'(i);
    e.mm = 6'($countones(d));
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("equal", {31'd0, equal}, {31'd0, e.eq});
        chk("first_diff", {26'd0, first_diff}, {26'd0, e.fd});
`ifdef SERIAL_EQ_MISMATCH_COUNT_EN
        chk("mismatch_cnt", {26'd0, mismatch_cnt}, {26'd0, e.mm});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [W-1:0] xw, input logic [W-1:0] yw,
                          input int gap, input int poke_after, input int junk);
    exp_t e;
    e = model(xw, yw);
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1; x = 1'b1; y = 1'b0;
      tick();
      chk("idle_ready", {31'd0, in_ready}, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start_eq_clear", {31'd0, equal}, 0);
    chk("start_fd_clear", {26'd0, first_diff}, 0);
    chk("start_ready", {31'd0, in_ready}, 1);
    chk("start_busy", {31'd0, busy}, 1);
    sb.push_back(e);
    words++;
    for (int i = 0; i < W; i++) begin
      if (i == poke_after) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("poke_ready", {31'd0, in_ready}, 1);
      end
      in_valid = 1'b1; x = xw[i]; y = yw[i];
      tick();
      in_valid = 1'b0;
      if (i < W - 1) begin
        chk("run_ready", {31'd0, in_ready}, 1);
        chk("run_no_done", {31'd0, done}, 0);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_ready", {31'd0, in_ready}, 1);
        end
      end
    end
    chk("done_latency", {31'd0, done}, 1);
    tick();
    chk("done_pulse", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    tick();
    tick();
    chk("hold_eq", {31'd0, equal}, {31'd0, e.eq});
    chk("hold_fd", {26'd0, first_diff}, {26'd0, e.fd});
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; x = 1'b0; y = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_equal", {31'd0, equal}, 0);
    chk("rst_fd", {26'd0, first_diff}, 0);
    reset = 1'b0;
    tick();

    run_word(4'b1010, 4'b1010, 0, -1, 0);
    run_word(4'b0110, 4'b0011, 0, -1, 0);
    run_word(4'b1100, 4'b1100, 3, -1, 0);
    run_word(4'b0111, 4'b0101, 0, 2, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = 1'b1; y = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, in_ready}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_equal", {31'd0, equal}, 0);
    tick();
    chk("abort_no_done", {31'd0, done}, 0);
    run_word(4'b1001, 4'b1101, 1, -1, 0);

    run_word(4'b0101, 4'b0101, 0, -1, 3);

    for (int n = 0; n < 30; n++) begin
      rx = W'($urandom);
      ry = ($urandom_range(0, 2) == 0) ? rx : W'($urandom);
      run_word(rx, ry, int'($urandom_range(0, 2)), -1, int'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 0);
    chk("done_count", done_seen, words);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_eq_checker.md
SERIAL_EQ_CHECKER -- requirements
Module: serial_eq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of bit pairs per compared word (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1, a request to begin a new word comparison.
REQ-005 SHALL have port in_valid, input, 1, which qualifies the x/y bit pair.
REQ-006 SHALL have port x, input, 1, a serial bit of word X, LSB first.
REQ-007 SHALL have port y, input, 1, a serial bit of word Y, LSB first.
REQ-008 SHALL have port in_ready, output, 1, high when a bit pair can be accepted.
REQ-009 SHALL have port busy, output, 1, high while in RUN or DONE.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when a word result is valid.
REQ-011 SHALL have port equal, output, 1, which is 1 when all WIDTH pairs matched (XNOR true for every bit).
REQ-012 SHALL have port first_diff, output, 6, the index of the first mismatching pair, or WIDTH when no pair mismatched.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE->RUN when start=1.
- RUN->DONE on the cycle the WIDTH-th pair is accepted.
- DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL accept a pair when in_valid=1 and in_ready=1; in_ready SHALL be 1 only in RUN (in_ready = state==RUN).
REQ-015 SHALL ignore in_valid in IDLE and DONE; pairs presented there SHALL be dropped and SHALL NOT be counted.
REQ-016 SHALL use a bit counter of 0..WIDTH-1 that clears on start and increments per accepted pair, without wrap-around inside a word.
REQ-017 SHALL compute the per-pair match as ~(x^y) and AND it into a running match flag that is initialised to 1 on start.
REQ-018 SHALL capture first_diff as the counter value at the first mismatch of the word; later mismatches SHALL NOT overwrite it.
REQ-019 SHALL assert done, and update equal and first_diff, on the clock edge after the WIDTH-th pair is accepted (one cycle of latency); done SHALL be high only in DONE.
REQ-020 SHALL hold equal and first_diff stable from done until the next accepted start, at which point they clear to 0 and 0.
REQ-021 SHALL ignore start in RUN and DONE, so that an in-progress word is never restarted.
REQ-022 SHALL hold the counter and flags when in_valid=0 in RUN; gaps of any length between pairs SHALL be legal.
REQ-023 SHALL, for WIDTH=1, accept a single pair and then go RUN->DONE.

Reset
REQ-024 SHALL, with reset=1 at a clock edge, set state to IDLE, counter to 0, in_ready, busy, done and equal to 0, first_diff to 0, and mismatch_cnt (if present) to 0.
REQ-025 SHALL give reset priority over start and in_valid in the same cycle; a reset in RUN SHALL abort the word with no done pulse.

Configuration
REQ-026 SHALL, when macro SERIAL_EQ_MISMATCH_COUNT_EN is defined, add the output port mismatch_cnt (6 bits), which counts mismatching pairs in the word.
- Cleared on start.
- Saturates at WIDTH.
- Valid and held under the same rules as equal.
REQ-027 SHALL, when that macro is undefined, omit the mismatch_cnt port and its logic, with all other behaviour identical.

Verification (WIDTH=4)
REQ-028 SHALL cover: start, then X=4'b1010, Y=4'b1010 sent back-to-back -> done one cycle after the 4th pair, equal=1, first_diff=4, mismatch_cnt=0.
REQ-029 SHALL cover: X=4'b0110, Y=4'b0011 (LSB first: pairs 0/1, 1/1, 1/0, 0/0) -> equal=0, first_diff=0, mismatch_cnt=2.
REQ-030 SHALL cover: in_valid gaps of 3 cycles between each pair of an equal word -> done only after the 4th accepted pair, equal=1, with in_ready held high throughout RUN.
REQ-031 SHALL cover: start asserted during RUN after 2 pairs -> ignored; the word completes after 2 more pairs with a single done pulse.
REQ-032 SHALL cover: reset asserted after 3 pairs -> next cycle in IDLE, busy=0, no done, equal=0; a fresh start then compares a new word correctly.
REQ-033 SHALL cover: in_valid=1 in IDLE with pairs 1/0 followed by start and 4 equal pairs -> the pre-start pairs are not counted and equal=1.
